// File: rtl/systolic_sequencer_pkg.sv
// Shared types and sizing helpers for the systolic array job sequencer.
package systolic_sequencer_pkg;

  localparam int unsigned SEQ_N     = 8;
  localparam int unsigned SEQ_LEN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_PRIME = 3'd4,
    ST_READ  = 3'd5
  } seq_state_e;

  // Row/flush counter must reach N itself (rows-loaded count).
  function automatic int unsigned row_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_sequencer_out_reg.sv
// Single-entry result register with valid/ready handshake and last-row flag.
module seq_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // A load in the same cycle as a handshake replaces the word, keeping valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer for the NxN bit-level systolic accumulate array: feed, flush, prime, read.
// SYSTOLIC_SEQ_CLEAR_EN adds a CLEAR state that pulses sa_clear at the start of every job.
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int unsigned N     = SEQ_N,
  parameter int unsigned LEN_W = SEQ_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_xor,
  input  logic [LEN_W-1:0] len,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [N-1:0]     a_data,
  input  logic [N-1:0]     b_data,
  output logic [N-1:0]     sa_in1,
  output logic [N-1:0]     sa_in2,
  output logic             sa_valid,
  output logic             sa_readout,
  output logic             sa_usexor,
  output logic             sa_clear,
  input  logic [N-1:0]     sa_out,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [N-1:0]     r_data,
  output logic             r_last,
  output logic             busy
);

  localparam int unsigned        CNT_W    = row_cnt_w(N);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(N);

  seq_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rd_load;
  logic             r_fire;

  assign r_fire = r_valid && r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      len_q      <= '0;
      pair_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      pair_cnt_q <= pair_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // cnt_q counts flush steps in FLUSH and rows loaded into the output register in READ.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    pair_cnt_d = pair_cnt_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = op_xor;
          len_d      = len;
          pair_cnt_d = '0;
          cnt_d      = '0;
`ifdef SYSTOLIC_SEQ_CLEAR_EN
          state_d    = ST_CLEAR;
`else
          state_d    = (len == '0) ? ST_FLUSH : ST_FEED;
`endif
        end
      end
      ST_CLEAR: begin
        state_d = (len_q == '0) ? ST_FLUSH : ST_FEED;
      end
      ST_FEED: begin
        if (a_valid) begin
          pair_cnt_d = LEN_W'(pair_cnt_q + LEN_W'(1));
          if (LEN_W'(pair_cnt_q + LEN_W'(1)) == len_q) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_PRIME;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      ST_PRIME: begin
        cnt_d   = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        if (rd_load) begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
        if (r_fire && r_last) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Array controls; operands pass straight through only on an accepted pair.
  always_comb begin
    a_ready    = 1'b0;
    sa_in1     = '0;
    sa_in2     = '0;
    sa_valid   = 1'b0;
    sa_readout = 1'b0;
    sa_clear   = 1'b0;
    rd_load    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
`ifdef SYSTOLIC_SEQ_CLEAR_EN
        sa_clear = 1'b1;
`endif
      end
      ST_FEED: begin
        a_ready = 1'b1;
        if (a_valid) begin
          sa_valid = 1'b1;
          sa_in1   = a_data;
          sa_in2   = b_data;
        end
      end
      ST_FLUSH: begin
        sa_valid = 1'b1;
      end
      ST_PRIME: begin
        sa_readout = 1'b1;
      end
      ST_READ: begin
        // Shift only when the output register can take the word and rows remain.
        rd_load    = (!r_valid || r_ready) && (cnt_q != CNT_FULL);
        sa_readout = rd_load;
      end
      default: begin
        a_ready = 1'b0;
      end
    endcase
    busy      = (state_q != ST_IDLE);
    sa_usexor = (state_q != ST_IDLE) && mode_q;
  end

  seq_out_reg #(
    .W (N)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rd_load),
    .load_data (sa_out),
    .load_last (cnt_q == CNT_LAST),
    .out_ready (r_ready),
    .out_valid (r_valid),
    .out_data  (r_data),
    .out_last  (r_last)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench: behavioural array model plus a scoreboard of expected result rows.
module tb_systolic_sequencer;

  localparam int unsigned N     = 8;
  localparam int unsigned LEN_W = 4;
`ifdef SYSTOLIC_SEQ_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  typedef struct packed {
    logic [N-1:0] data;
    logic         last;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op_xor;
  logic [LEN_W-1:0] len;
  logic             a_valid;
  logic             a_ready;
  logic [N-1:0]     a_data;
  logic [N-1:0]     b_data;
  logic [N-1:0]     sa_in1;
  logic [N-1:0]     sa_in2;
  logic             sa_valid;
  logic             sa_readout;
  logic             sa_usexor;
  logic             sa_clear;
  logic [N-1:0]     sa_out;
  logic             r_valid;
  logic             r_ready;
  logic [N-1:0]     r_data;
  logic             r_last;
  logic             busy;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [N-1:0] pa[$];
  logic [N-1:0] pb[$];
  bit           job_op;
  int           rows_seen;
  bit           prev_rv;
  bit           prev_fire;
  exp_t         mon_e;

  systolic_sequencer #(
    .N     (N),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_xor     (op_xor),
    .len        (len),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .b_data     (b_data),
    .sa_in1     (sa_in1),
    .sa_in2     (sa_in2),
    .sa_valid   (sa_valid),
    .sa_readout (sa_readout),
    .sa_usexor  (sa_usexor),
    .sa_clear   (sa_clear),
    .sa_out     (sa_out),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_last     (r_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: outer-product accumulate on steps, shift toward row N-1 on readout.
  logic [N-1:0] arr [N];
  logic [N-1:0] arr_out;
  assign sa_out = sa_readout ? arr_out : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) arr[i] <= '0;
      arr_out <= '0;
    end else if (sa_clear) begin
      for (int i = 0; i < N; i++) arr[i] <= '0;
    end else if (sa_valid) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (sa_in1[i] && sa_in2[j]) arr[i][j] <= sa_usexor ? ~arr[i][j] : 1'b1;
    end else if (sa_readout) begin
      arr_out <= arr[N-1];
      for (int i = 1; i < N; i++) arr[i] <= arr[i-1];
      arr[0] <= '0;
    end
  end

  // Monitor: scoreboard pops and protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r_valid && r_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_row: got data=%h last=%b, required no row", r_data, r_last);
        end else begin
          mon_e = sb.pop_front();
          if (r_data !== mon_e.data || r_last !== mon_e.last) begin
            errors++;
            $display("FAIL row: got data=%h last=%b, required data=%h last=%b",
                     r_data, r_last, mon_e.data, mon_e.last);
          end
        end
        rows_seen++;
      end
      if (r_valid && !r_ready) begin
        checks++;
        if (sa_readout !== 1'b0) begin
          errors++;
          $display("FAIL readout_stall: got sa_readout=%b, required 0", sa_readout);
        end
      end
      if (a_ready && !a_valid) begin
        checks++;
        if ({sa_valid, sa_in1, sa_in2} !== '0) begin
          errors++;
          $display("FAIL feed_gap: got valid=%b in1=%h in2=%h, required all 0",
                   sa_valid, sa_in1, sa_in2);
        end
      end
      if (a_ready && a_valid) begin
        checks++;
        if (sa_valid !== 1'b1 || sa_in1 !== a_data || sa_in2 !== b_data) begin
          errors++;
          $display("FAIL feed_pass: got valid=%b in1=%h in2=%h, required 1 %h %h",
                   sa_valid, sa_in1, sa_in2, a_data, b_data);
        end
      end
      if (prev_rv && !prev_fire) begin
        checks++;
        if (r_valid !== 1'b1) begin
          errors++;
          $display("FAIL rvalid_drop: got r_valid=%b, required 1", r_valid);
        end
      end
      checks++;
      if (sa_usexor !== (busy ? job_op : 1'b0)) begin
        errors++;
        $display("FAIL usexor: got %b, required %b", sa_usexor, busy ? job_op : 1'b0);
      end
      if (!busy) begin
        checks++;
        if ({a_ready, sa_valid, sa_readout, sa_clear} !== 4'b0) begin
          errors++;
          $display("FAIL idle_ctrl: got ready/valid/readout/clear=%b%b%b%b, required 0000",
                   a_ready, sa_valid, sa_readout, sa_clear);
        end
      end
      prev_rv   = r_valid;
      prev_fire = r_valid && r_ready;
    end else begin
      prev_rv   = 1'b0;
      prev_fire = 1'b0;
    end
  end

  // Drives one job from pa/pb and pushes the expected rows (row N-1 first).
  task automatic run_job(input bit op, input int n, input bit gaps, input bit rr_tog,
                         input bit poke, output int bcyc, output logic bpre,
                         output int clr_cnt, output bit saw_ready, output bit done);
    logic [N-1:0] w;
    exp_t         e;
    int           idx;
    for (int r = N - 1; r >= 0; r--) begin
      w = '0;
      for (int k = 0; k < n; k++)
        if (pa[k][r]) w = op ? (w ^ pb[k]) : (w | pb[k]);
      e.data = w;
      e.last = (r == 0);
      sb.push_back(e);
    end
    job_op = op; rows_seen = 0; bcyc = 0; clr_cnt = 0; saw_ready = 0; done = 0; idx = 0;
    @(posedge clk); #1;
    start = 1'b1; op_xor = op; len = LEN_W'(n); a_valid = 1'b0; r_ready = 1'b1;
    @(negedge clk);
    bpre = busy;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      op_xor  = 1'($urandom);
      len     = LEN_W'($urandom);
      start   = poke && (cyc == 5);
      a_valid = (idx < n) && !(gaps && (cyc % 3 == 1));
      if (a_valid) begin
        a_data = pa[idx];
        b_data = pb[idx];
      end else begin
        a_data = N'($urandom);
        b_data = N'($urandom);
      end
      r_ready = rr_tog ? cyc[0] : 1'b1;
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
      bcyc++;
      if (sa_clear) clr_cnt++;
      if (a_ready) saw_ready = 1;
      if (a_valid && a_ready) idx++;
      @(posedge clk); #1;
    end
    start = 1'b0; a_valid = 1'b0; r_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL job_timeout: got busy still high after 400 cycles, required job end");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ready, sa_valid, sa_readout, sa_usexor, sa_clear, r_valid, r_last, busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {a_ready, sa_valid, sa_readout, sa_usexor, sa_clear, r_valid, r_last, busy});
    end
    checks++;
    if ({sa_in1, sa_in2, r_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got in1=%h in2=%h r_data=%h, required 0", sa_in1, sa_in2, r_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got busy=%b r_valid=%b, required 0 0", busy, r_valid);
    end
  endtask

  task automatic check_job(input string name, input int rows_req, input int bcyc,
                           input int bcyc_req);
    checks++;
    if (rows_seen != rows_req || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_rows: got rows=%0d left=%0d, required rows=%0d left=0",
               name, rows_seen, sb.size(), rows_req);
    end
    if (bcyc_req >= 0) begin
      checks++;
      if (bcyc != bcyc_req) begin
        errors++;
        $display("FAIL %s_busy_cycles: got %0d, required %0d", name, bcyc, bcyc_req);
      end
    end
  endtask

  // Busy cycles with r_ready high: CLEAR + len FEED + N FLUSH + PRIME + N+1 READ.
  task automatic test_or_basic();
    int bc, cc; logic bp; bit sr, dn;
    pa.delete(); pb.delete();
    pa.push_back(8'hFF); pb.push_back(8'hFF);
    run_job(1'b0, 1, 1'b0, 1'b0, 1'b0, bc, bp, cc, sr, dn);
    check_job("or_basic", N, bc, CLR + 1 + 2 * N + 2);
    checks++;
    if (bp !== 1'b0) begin
      errors++;
      $display("FAIL busy_rise: got busy=%b in start cycle, required 0", bp);
    end
    checks++;
    if (cc != CLR) begin
      errors++;
      $display("FAIL clear_pulses: got %0d, required %0d", cc, CLR);
    end
    checks++;
    if (r_valid !== 1'b0 || r_last !== 1'b0) begin
      errors++;
      $display("FAIL or_basic_tail: got r_valid=%b r_last=%b, required 0 0", r_valid, r_last);
    end
  endtask

  task automatic test_xor();
    int bc, cc; logic bp; bit sr, dn;
    pa.delete(); pb.delete();
    repeat (2) begin
      pa.push_back(8'h0F); pb.push_back(8'hFF);
    end
    run_job(1'b1, 2, 1'b0, 1'b0, 1'b0, bc, bp, cc, sr, dn);
    check_job("xor", N, bc, CLR + 2 + 2 * N + 2);
  endtask

  task automatic test_len_zero();
    int bc, cc; logic bp; bit sr, dn;
    pa.delete(); pb.delete();
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b0, bc, bp, cc, sr, dn);
    check_job("len_zero", N, bc, CLR + 2 * N + 2);
    checks++;
    if (sr !== 1'b0) begin
      errors++;
      $display("FAIL len_zero_ready: got a_ready seen=%b, required 0", sr);
    end
  endtask

  task automatic test_rready_toggle();
    int bc, cc; logic bp; bit sr, dn;
    pa.delete(); pb.delete();
    for (int k = 0; k < 5; k++) begin
      pa.push_back(N'($urandom)); pb.push_back(N'($urandom));
    end
    run_job(1'b0, 5, 1'b0, 1'b1, 1'b0, bc, bp, cc, sr, dn);
    check_job("rready_toggle", N, bc, -1);
  endtask

  task automatic test_gaps();
    int bc0, bc1, cc; logic bp; bit sr, dn;
    pa.delete(); pb.delete();
    for (int k = 0; k < 4; k++) begin
      pa.push_back(N'($urandom)); pb.push_back(N'($urandom));
    end
    run_job(1'b1, 4, 1'b0, 1'b0, 1'b0, bc0, bp, cc, sr, dn);
    check_job("gap_free", N, bc0, CLR + 4 + 2 * N + 2);
    run_job(1'b1, 4, 1'b1, 1'b0, 1'b0, bc1, bp, cc, sr, dn);
    check_job("gaps", N, bc1, -1);
    checks++;
    if (bc1 <= bc0) begin
      errors++;
      $display("FAIL gaps_stretch: got %0d busy cycles, required more than %0d", bc1, bc0);
    end
  endtask

  task automatic test_start_ignored();
    int bc, cc; logic bp; bit sr, dn;
    pa.delete(); pb.delete();
    pa.push_back(8'h81); pb.push_back(8'h42);
    pa.push_back(8'h18); pb.push_back(8'h24);
    run_job(1'b0, 2, 1'b0, 1'b0, 1'b1, bc, bp, cc, sr, dn);
    check_job("start_ignored", N, bc, CLR + 2 + 2 * N + 2);
  endtask

  task automatic test_reset_mid();
    int bc, cc; logic bp; bit sr, dn;
    bit hit;
    hit = 0;
    job_op = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op_xor = 1'b1; len = LEN_W'(3); r_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; a_data = 8'hA5; b_data = 8'h3C;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy && sa_valid && !a_ready) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_flush: got no FLUSH cycle within 60 cycles, required one");
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ready, sa_valid, sa_readout, sa_usexor, sa_clear, r_valid, r_last, busy} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %b, required 00000000",
               {a_ready, sa_valid, sa_readout, sa_usexor, sa_clear, r_valid, r_last, busy});
    end
    checks++;
    if ({sa_in1, sa_in2, r_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_data: got in1=%h in2=%h r_data=%h, required 0",
               sa_in1, sa_in2, r_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    pa.delete(); pb.delete();
    pa.push_back(8'h5A); pb.push_back(8'hC3);
    pa.push_back(8'h0F); pb.push_back(8'h81);
    pa.push_back(8'hF0); pb.push_back(8'h7E);
    run_job(1'b0, 3, 1'b0, 1'b0, 1'b0, bc, bp, cc, sr, dn);
    check_job("after_reset", N, bc, CLR + 3 + 2 * N + 2);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; op_xor = 1'b0; len = '0;
    a_valid = 1'b0; a_data = '0; b_data = '0; r_ready = 1'b1;
    job_op = 1'b0; rows_seen = 0; prev_rv = 1'b0; prev_fire = 1'b0;
    #2;
    test_reset();
    test_or_basic();
    test_xor();
    test_len_zero();
    test_rready_toggle();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
